// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : isa_pkg
//  Purpose   : Shared definitions for the 32-bit instruction format:
//              opcodes, mnemonic indices, operand formats, field positions.
//  Revision  : 1.0 - initial release
// ============================================================================
package isa_pkg;

  // Field positions within the instruction word
  localparam int OPC_LSB = 25;
  localparam int DA_LSB  = 20;
  localparam int AA_LSB  = 15;
  localparam int BA_LSB  = 10;
  localparam int IMM_LSB = 0;
  localparam int REG_W   = 5;
  localparam int OPC_W   = 7;
  localparam int IMM_W   = 15;

  // Operand formats; each one selects which fields reach the word
  typedef enum logic [3:0] {
    FMT_Z  = 4'd0,
    FMT_R3 = 4'd1,
    FMT_R2 = 4'd2,
    FMT_S  = 4'd3,
    FMT_I  = 4'd4,
    FMT_A  = 4'd5,
    FMT_B  = 4'd6,
    FMT_J  = 4'd7,
    FMT_L  = 4'd8
  } fmt_e;

  // Mnemonic indices as presented on the input beat
  localparam logic [4:0] MN_NOP = 5'd0,  MN_ADD = 5'd1,  MN_SUB = 5'd2,  MN_SLT = 5'd3;
  localparam logic [4:0] MN_AND = 5'd4,  MN_OR  = 5'd5,  MN_XOR = 5'd6,  MN_ST  = 5'd7;
  localparam logic [4:0] MN_LD  = 5'd8,  MN_ADI = 5'd9,  MN_SBI = 5'd10, MN_NOT = 5'd11;
  localparam logic [4:0] MN_ANI = 5'd12, MN_ORI = 5'd13, MN_XRI = 5'd14, MN_AIU = 5'd15;
  localparam logic [4:0] MN_SIU = 5'd16, MN_MOV = 5'd17, MN_LSL = 5'd18, MN_LSR = 5'd19;
  localparam logic [4:0] MN_JMR = 5'd20, MN_BZ  = 5'd21, MN_BNZ = 5'd22, MN_JMP = 5'd23;
  localparam logic [4:0] MN_JML = 5'd24;

  // Opcodes
  localparam logic [6:0] OP_NOP = 7'b0000000, OP_ADD = 7'b0000010, OP_SUB = 7'b0000101;
  localparam logic [6:0] OP_SLT = 7'b1100101, OP_AND = 7'b0001000, OP_OR  = 7'b0001010;
  localparam logic [6:0] OP_XOR = 7'b0001100, OP_ST  = 7'b0000001, OP_LD  = 7'b0100001;
  localparam logic [6:0] OP_ADI = 7'b0100010, OP_SBI = 7'b0100101, OP_NOT = 7'b0101110;
  localparam logic [6:0] OP_ANI = 7'b0101000, OP_ORI = 7'b0101010, OP_XRI = 7'b0101100;
  localparam logic [6:0] OP_AIU = 7'b1100010, OP_SIU = 7'b1000101, OP_MOV = 7'b1000000;
  localparam logic [6:0] OP_LSL = 7'b0110000, OP_LSR = 7'b0110001, OP_JMR = 7'b1100001;
  localparam logic [6:0] OP_BZ  = 7'b0100000, OP_BNZ = 7'b1100000, OP_JMP = 7'b1000100;
  localparam logic [6:0] OP_JML = 7'b0000111;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
//  Module    : instr_pack
//  Purpose   : Combinational packer from a symbolic beat to a 32-bit word,
//              flagging mnemonic indices outside the defined set.
//  Revision  : 1.0 - initial release
// ============================================================================
module instr_pack
  import isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  da,
  input  logic [4:0]  aa,
  input  logic [4:0]  ba,
  input  logic [14:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [6:0] opcode;
  fmt_e       fmt;

  // Mnemonic index to opcode and operand format
  always_comb begin
    opcode  = OP_NOP;
    fmt     = FMT_Z;
    illegal = 1'b0;
    case (mnem)
      MN_NOP: begin opcode = OP_NOP; fmt = FMT_Z;  end
      MN_ADD: begin opcode = OP_ADD; fmt = FMT_R3; end
      MN_SUB: begin opcode = OP_SUB; fmt = FMT_R3; end
      MN_SLT: begin opcode = OP_SLT; fmt = FMT_R3; end
      MN_AND: begin opcode = OP_AND; fmt = FMT_R3; end
      MN_OR:  begin opcode = OP_OR;  fmt = FMT_R3; end
      MN_XOR: begin opcode = OP_XOR; fmt = FMT_R3; end
      MN_ST:  begin opcode = OP_ST;  fmt = FMT_S;  end
      MN_LD:  begin opcode = OP_LD;  fmt = FMT_R2; end
      MN_ADI: begin opcode = OP_ADI; fmt = FMT_I;  end
      MN_SBI: begin opcode = OP_SBI; fmt = FMT_I;  end
      MN_NOT: begin opcode = OP_NOT; fmt = FMT_R2; end
      MN_ANI: begin opcode = OP_ANI; fmt = FMT_I;  end
      MN_ORI: begin opcode = OP_ORI; fmt = FMT_I;  end
      MN_XRI: begin opcode = OP_XRI; fmt = FMT_I;  end
      MN_AIU: begin opcode = OP_AIU; fmt = FMT_I;  end
      MN_SIU: begin opcode = OP_SIU; fmt = FMT_I;  end
      MN_MOV: begin opcode = OP_MOV; fmt = FMT_R2; end
      MN_LSL: begin opcode = OP_LSL; fmt = FMT_R2; end
      MN_LSR: begin opcode = OP_LSR; fmt = FMT_R2; end
      MN_JMR: begin opcode = OP_JMR; fmt = FMT_A;  end
      MN_BZ:  begin opcode = OP_BZ;  fmt = FMT_B;  end
      MN_BNZ: begin opcode = OP_BNZ; fmt = FMT_B;  end
      MN_JMP: begin opcode = OP_JMP; fmt = FMT_J;  end
      MN_JML: begin opcode = OP_JML; fmt = FMT_L;  end
      default: illegal = 1'b1;
    endcase
  end

  // Field assembly; fields a format does not use stay zero
  always_comb begin
    word = 32'd0;
    word[OPC_LSB +: OPC_W] = opcode;
    case (fmt)
      FMT_R3: begin
        word[DA_LSB +: REG_W] = da;
        word[AA_LSB +: REG_W] = aa;
        word[BA_LSB +: REG_W] = ba;
      end
      FMT_R2: begin
        word[DA_LSB +: REG_W] = da;
        word[AA_LSB +: REG_W] = aa;
      end
      FMT_S: begin
        word[AA_LSB +: REG_W] = aa;
        word[BA_LSB +: REG_W] = ba;
      end
      FMT_I: begin
        word[DA_LSB +: REG_W]  = da;
        word[AA_LSB +: REG_W]  = aa;
        word[IMM_LSB +: IMM_W] = imm;
      end
      FMT_A: word[AA_LSB +: REG_W] = aa;
      FMT_B: begin
        word[AA_LSB +: REG_W]  = aa;
        word[IMM_LSB +: IMM_W] = imm;
      end
      FMT_J: word[IMM_LSB +: IMM_W] = imm;
      FMT_L: begin
        word[DA_LSB +: REG_W]  = da;
        word[IMM_LSB +: IMM_W] = imm;
      end
      default: word = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instruction_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module    : instruction_encoder_loader
//  Purpose   : Accepts symbolic instruction beats, packs them into 32-bit
//              words and writes them to consecutive instruction memory words.
//  Revision  : 1.0 - initial release
// ============================================================================
module instruction_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_da,
  input  logic [4:0]        in_aa,
  input  logic [4:0]        in_ba,
  input  logic [14:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   err_index,
  output logic              wrapped
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W:0]   accepted_q,  accepted_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] waddr_q,     waddr_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic              wrapped_q,   wrapped_d;
  logic [ADDR_W:0]   err_index_q, err_index_d;

  logic [31:0]       w_pack_word;
  logic              w_pack_illegal;

  instr_pack u_pack (
    .mnem    (in_mnem),
    .da      (in_da),
    .aa      (in_aa),
    .ba      (in_ba),
    .imm     (in_imm),
    .word    (w_pack_word),
    .illegal (w_pack_illegal)
  );

  // State and datapath registers; reset also cancels a pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      accepted_q  <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wrapped_q   <= 1'b0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      accepted_q  <= accepted_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wrapped_q   <= wrapped_d;
      err_index_q <= err_index_d;
    end
  end

  // Next-state logic; abort outranks a simultaneous transfer
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    accepted_d  = accepted_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wrapped_d   = wrapped_q;
    err_index_d = err_index_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = word_count;
          accepted_d  = '0;
          wrapped_d   = 1'b0;
          err_index_d = '0;
          state_d     = (word_count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          if (w_pack_illegal) begin
            err_index_d = accepted_q;
            state_d     = ST_ERROR;
          end else begin
            we_d        = 1'b1;
            waddr_d     = addr_q;
            wdata_d     = w_pack_word;
            addr_d      = addr_q + 1'b1;
            wrapped_d   = wrapped_q | (&addr_q);
            remaining_d = remaining_q - 1'b1;
            accepted_d  = accepted_q + 1'b1;
            if (remaining_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: state_d = abort ? ST_IDLE : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign err_index  = err_index_q;
  assign wrapped    = wrapped_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module    : tb_instruction_encoder_loader
//  Purpose   : Directed self-checking bench for instruction_encoder_loader.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  word_count;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_mnem, in_da, in_aa, in_ba;
  logic [14:0] in_imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, error, wrapped;
  logic [8:0]  err_index;

  int total = 0;
  int bad   = 0;

  instruction_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .in_mnem(in_mnem), .in_da(in_da), .in_aa(in_aa),
    .in_ba(in_ba), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic start_session(input logic [7:0] b, input logic [8:0] n);
    base_addr = b; word_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_beat(input logic [4:0] m, input logic [4:0] d, input logic [4:0] a,
                          input logic [4:0] bb, input logic [14:0] i);
    in_mnem = m; in_da = d; in_aa = a; in_ba = bb; in_imm = i;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base_addr = '0; word_count = '0; set_beat(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    total++; if ({imem_we, busy, done, error, wrapped, in_ready} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000", {imem_we, busy, done, error, wrapped, in_ready}); end
    total++; if ({imem_addr, imem_wdata, err_index} !== 49'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {imem_addr, imem_wdata, err_index}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One-beat session at 0x10; checks write timing, data and done pulse
  task automatic test_single(input string nm, input logic [4:0] m, input logic [4:0] d,
                             input logic [4:0] a, input logic [4:0] bb, input logic [14:0] i,
                             input logic [31:0] exp_word);
    start_session(8'h10, 9'd1);
    total++; if ({in_ready, busy} !== 2'b11) begin
      bad++; $display("FAIL %s_load got=%b want=11", nm, {in_ready, busy}); end
    set_beat(m, d, a, bb, i); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({imem_we, in_ready, done} !== 3'b100 || imem_addr !== 8'h10) begin
      bad++; $display("FAIL %s_write got=%b/%h want=100/10", nm, {imem_we, in_ready, done}, imem_addr); end
    total++; if (imem_wdata !== exp_word) begin
      bad++; $display("FAIL %s_wdata got=%h want=%h", nm, imem_wdata, exp_word); end
    @(negedge clk);
    total++; if ({done, imem_we, busy} !== 3'b100) begin
      bad++; $display("FAIL %s_done got=%b want=100", nm, {done, imem_we, busy}); end
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL %s_idle got=%b want=00", nm, {done, busy}); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr [3];
    int dones;
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00;
    start_session(8'hFE, 9'd3);
    set_beat(0, 5'd9, 5'd9, 5'd9, 15'h1111); in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) in_valid = 1'b0;
      total++; if (imem_we !== 1'b1 || imem_addr !== exp_addr[k] || imem_wdata !== 32'd0) begin
        bad++; $display("FAIL wrap_write%0d got=%b/%h/%h want=1/%h/0", k, imem_we, imem_addr, imem_wdata, exp_addr[k]); end
    end
    total++; if (wrapped !== 1'b1) begin
      bad++; $display("FAIL wrap_flag got=%b want=1", wrapped); end
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++; if (dones != 1) begin
      bad++; $display("FAIL wrap_done_count got=%0d want=1", dones); end
    total++; if (wrapped !== 1'b1) begin
      bad++; $display("FAIL wrap_sticky got=%b want=1", wrapped); end
  endtask

  task automatic test_error();
    start_session(8'h20, 9'd4);
    total++; if (wrapped !== 1'b0) begin
      bad++; $display("FAIL err_wrap_clear got=%b want=0", wrapped); end
    set_beat(5'd1, 5'd3, 5'd1, 5'd2, 15'd0); in_valid = 1'b1;
    @(negedge clk);
    total++; if (imem_we !== 1'b1 || imem_addr !== 8'h20) begin
      bad++; $display("FAIL err_write0 got=%b/%h want=1/20", imem_we, imem_addr); end
    @(negedge clk);
    total++; if (imem_we !== 1'b1 || imem_addr !== 8'h21) begin
      bad++; $display("FAIL err_write1 got=%b/%h want=1/21", imem_we, imem_addr); end
    in_mnem = 5'd27;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({imem_we, error, in_ready, busy} !== 4'b0100 || err_index !== 9'd2) begin
      bad++; $display("FAIL err_state got=%b/%0d want=0100/2", {imem_we, error, in_ready, busy}, err_index); end
    @(negedge clk);
    total++; if ({imem_we, error} !== 2'b01) begin
      bad++; $display("FAIL err_hold got=%b want=01", {imem_we, error}); end
    start_session(8'h00, 9'd0);
    total++; if ({error, done} !== 2'b01 || err_index !== 9'd0) begin
      bad++; $display("FAIL err_restart got=%b/%0d want=01/0", {error, done}, err_index); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int writes, dones;
    start_session(8'h30, 9'd4);
    set_beat(5'd2, 5'd1, 5'd1, 5'd1, 15'd0); in_valid = 1'b1;
    @(negedge clk);
    total++; if (imem_we !== 1'b1 || imem_addr !== 8'h30) begin
      bad++; $display("FAIL abort_write0 got=%b/%h want=1/30", imem_we, imem_addr); end
    @(negedge clk);
    abort = 1'b1;
    total++; if (imem_we !== 1'b1 || imem_addr !== 8'h31) begin
      bad++; $display("FAIL abort_write1 got=%b/%h want=1/31", imem_we, imem_addr); end
    // start in LOAD must be ignored
    start = 1'b1; base_addr = 8'h80; word_count = 9'd1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0; start = 1'b0;
    total++; if ({imem_we, busy, done, in_ready} !== 4'b0000) begin
      bad++; $display("FAIL abort_idle got=%b want=0000", {imem_we, busy, done, in_ready}); end
    writes = 0; dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (imem_we === 1'b1) writes++;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++; if (writes != 0 || dones != 0) begin
      bad++; $display("FAIL abort_quiet got=%0d/%0d want=0/0", writes, dones); end
  endtask

  task automatic test_reset_mid();
    start_session(8'h40, 9'd4);
    set_beat(5'd4, 5'd1, 5'd2, 5'd3, 15'd0); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (imem_we !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got=%b want=1", imem_we); end
    rst_n = 1'b0;
    #1;
    total++; if ({imem_we, busy, done, error, wrapped, in_ready} !== 6'b0 ||
                 {imem_addr, imem_wdata, err_index} !== 49'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%b/%h want=0/0",
                      {imem_we, busy, done, error, wrapped, in_ready}, {imem_addr, imem_wdata, err_index}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({imem_we, busy} !== 2'b00) begin
      bad++; $display("FAIL rstmid_after got=%b want=00", {imem_we, busy}); end
  endtask

  initial begin
    test_reset();
    test_single("add", 5'd1,  5'd3,  5'd1,  5'd2, 15'h0000, 32'h04308800);
    test_single("adi", 5'd9,  5'd5,  5'd4,  5'd6, 15'h7FFF, 32'h44527FFF);
    test_single("st",  5'd7,  5'd7,  5'd2,  5'd3, 15'h0000, 32'h02010C00);
    test_single("slt", 5'd3,  5'd1,  5'd1,  5'd1, 15'h7FFF, 32'hCA108400);
    test_single("not", 5'd11, 5'd2,  5'd4,  5'd7, 15'h7FFF, 32'h5C220000);
    test_single("jmr", 5'd20, 5'd1,  5'd31, 5'd2, 15'h0007, 32'hC20F8000);
    test_single("bz",  5'd21, 5'd9,  5'd3,  5'd4, 15'h0055, 32'h40018055);
    test_single("jmp", 5'd23, 5'd3,  5'd3,  5'd3, 15'h4ABC, 32'h88004ABC);
    test_single("jml", 5'd24, 5'd31, 5'd5,  5'd6, 15'h1234, 32'h0FF01234);
    test_wrap();
    test_error();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_encoder_loader.md
Name: instruction_encoder_loader

Overview:
- Producer side of the 32-bit instruction format.
- Accepts symbolic instruction beats (mnemonic index plus register and immediate fields) over a valid/ready handshake.
- Packs each beat into an instruction word and writes the words into instruction memory at consecutive addresses.
- Sits between the host/boot loader path and the instruction memory write port; used for program load and test-program generation.

Parameters:
- ADDR_W, 8, instruction memory address width in words.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begins a load session; ignored unless the FSM is in IDLE or ERROR
- base_addr  in  ADDR_W  first write address, sampled on start
- word_count  in  ADDR_W+1  number of beats in the session, sampled on start
- abort  in  1  ends the session and returns to IDLE
- in_valid  in  1  beat valid
- in_ready  out  1  beat accept; a transfer occurs when in_valid and in_ready are both high at a clock edge
- in_mnem  in  5  mnemonic index
- in_da, in_aa, in_ba  in  5 each  register fields
- in_imm  in  15  immediate
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded instruction word
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse when a session completes
- error  out  1  high in ERROR
- err_index  out  ADDR_W+1  number of beats accepted before the illegal beat
- wrapped  out  1  sticky; set when imem_addr wraps from all-ones to 0; cleared on start

Behaviour:
- Reset values: FSM=IDLE; all outputs 0; internal address and count registers 0.
- Word format: IR[31:25]=opcode, IR[24:20]=DA, IR[19:15]=AA, IR[14:10]=BA, IR[9:0]=0.
- Immediate formats place in_imm in IR[14:0]; BA is not encoded.
- Mnemonic index to opcode/format map, in index order:
  - 0 NOP 0000000 Z; 1 ADD 0000010 R3; 2 SUB 0000101 R3; 3 SLT 1100101 R3; 4 AND 0001000 R3; 5 OR 0001010 R3; 6 XOR 0001100 R3
  - 7 ST 0000001 S; 8 LD 0100001 R2; 9 ADI 0100010 I; 10 SBI 0100101 I; 11 NOT 0101110 R2; 12 ANI 0101000 I; 13 ORI 0101010 I
  - 14 XRI 0101100 I; 15 AIU 1100010 I; 16 SIU 1000101 I; 17 MOV 1000000 R2; 18 LSL 0110000 R2; 19 LSR 0110001 R2
  - 20 JMR 1100001 A; 21 BZ 0100000 B; 22 BNZ 1100000 B; 23 JMP 1000100 J; 24 JML 0000111 L
- Indices 25-31 are illegal.
- Formats; any field not listed is forced to 0:
  - Z: no fields (word = 0)
  - R3: DA, AA, BA
  - R2: DA, AA
  - S: AA, BA
  - I: DA, AA, IMM
  - A: AA
  - B: AA, IMM
  - J: IMM
  - L: DA, IMM
- The immediate is passed through unmodified; sign versus zero treatment belongs to the consumer.
- FSM states: IDLE, LOAD, DRAIN, DONE, ERROR.
  - IDLE or ERROR, start: load addr=base_addr and remaining=word_count; clear error and wrapped. Go to LOAD, or to DONE if word_count=0.
  - LOAD: in_ready=1. On a legal transfer: register the encoded word and address; imem_we=1 in the next cycle; addr+1 (mod 2^ADDR_W; set wrapped on the wrap); remaining-1. If remaining becomes 0, go to DRAIN.
  - LOAD, illegal transfer: no write; err_index = beats accepted so far; go to ERROR.
  - DRAIN: in_ready=0; the final write occurs this cycle; next state is DONE.
  - DONE: done=1 for one cycle; next state is IDLE.
- Latency: a beat accepted at edge N is written with imem_we high during cycle N+1. Back-to-back beats give one write per cycle.
- abort in LOAD or DRAIN: go to IDLE next cycle; no done pulse. A write already registered still completes in the following cycle. abort has priority over a simultaneous transfer, which is dropped: no write and no count change.
- start is ignored in LOAD, DRAIN and DONE.
- rst_n low at any time, including mid-session: immediate return to reset values; an in-flight write is cancelled.

Decomposition:
- Shared package isa_pkg holds:
  - opcode localparams (OP_ADD etc.)
  - mnemonic index constants
  - format enum (FMT_Z, FMT_R3, FMT_R2, FMT_S, FMT_I, FMT_A, FMT_B, FMT_J, FMT_L)
  - field bit-position constants
- The decoder is to be refactored onto the same package.
- One sub-module, instr_pack: combinational map from (mnem, da, aa, ba, imm) to (word, illegal). The sequential top wraps it.

Test Plan:
- start with base_addr=8'h10, word_count=1; beat ADD (1), DA=3, AA=1, BA=2 -> imem_we one cycle, addr=0x10, wdata=0x04308800; done pulse two cycles after the accept; busy low afterward.
- Beat ADI (9), DA=5, AA=4, imm=15'h7FFF -> wdata=0x44527FFF.
- Beat ST (7), DA=7, AA=2, BA=3 -> DA forced to 0; wdata=0x02010C00.
- base_addr=8'hFE, word_count=3; three NOP beats back-to-back -> writes to 0xFE, 0xFF, 0x00 on consecutive cycles; wrapped=1; single done pulse.
- word_count=4; beats ADD, ADD, mnem=27 -> two writes only; error=1, err_index=2, in_ready=0; a new start clears error.
- word_count=4; abort asserted the cycle after the second accept -> second write still occurs, no further writes, no done, IDLE next cycle. Also: rst_n low mid-session -> all outputs 0 immediately, including imem_we.
